ddram_arb: RTL

Round-robin arbiter that shares the single 8-bit DDR3 byte port among `NREQ` requesters, such as CPU-side RAM expansion, tape/disk image loaders and the OSD/ioctl downloader. It sits between the requesters and the byte-port controller. It converts a simple per-requester req/ack handshake into the controller's edge-triggered `rd`/`we` strobes and `ready` status. It also enforces the strobe low-time the controller needs to detect every new edge.

---
 rtl/ddram_arb_pkg.sv | 20 ++
 rtl/ddram_arb_rr_pick.sv | 31 +++
 rtl/ddram_arb.sv | 99 +++++++++
 3 files changed

// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the DDR3 byte-port arbiter.
package ddram_arb_pkg;

   localparam int DDR_AW = 28;
   localparam int DDR_DW = 8;

   typedef enum logic [2:0] {
      GAP,
      IDLE,
      ISSUE,
      WAIT_ACC,
      WAIT_DONE
   } arb_state_t;

   // Index width for a requester count (at least one bit).
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddram_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr+1, modulo NREQ.
module rr_pick
   import ddram_arb_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   grant,
   output logic            valid
);

   logic [PW-1:0] idx;

   // Scan farthest-first so the nearest requester after the pointer is the last write.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise a latch is inferred.
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddram_arb.sv
// Round-robin arbiter sharing the DDR3 byte port; turns req/ack into edge-triggered rd/we strobes.
module ddram_arb
   import ddram_arb_pkg::*;
#(
   parameter int NREQ = 3
) (
   input  logic                           DDRAM_CLK,
   input  logic                           reset,
   input  logic [NREQ-1:0]                req,
   input  logic [NREQ-1:0]                we,
   input  logic [NREQ-1:0][DDR_AW-1:0]    addr,
   input  logic [NREQ-1:0][DDR_DW-1:0]    wdata,
   output logic [NREQ-1:0]                ack,
   output logic [DDR_DW-1:0]              rdata,
   output logic [DDR_AW-1:0]              mem_addr,
   output logic [DDR_DW-1:0]              mem_din,
   output logic                           mem_we,
   output logic                           mem_rd,
   input  logic [DDR_DW-1:0]              mem_dout,
   input  logic                           mem_ready,
   input  logic                           mem_busy
);

   localparam int            PW      = idx_w(NREQ);
   localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

   arb_state_t    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [PW-1:0] pick_idx;
   logic          pick_valid;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (pick_idx),
      .valid (pick_valid)
   );

   // Pointer resets to the last requester so requester 0 is first in line.
   always_ff @(posedge DDRAM_CLK or posedge reset) begin
      if (reset) begin
         state    <= GAP;
         ptr      <= PTR_RST;
         win      <= '0;
         ack      <= '0;
         rdata    <= '0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_we   <= 1'b0;
         mem_rd   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same edge.
         ack <= '0;
         case (state)
            GAP: begin
               if (!mem_busy && mem_ready)
                  state <= IDLE;
            end
            IDLE: begin
               if (pick_valid) begin
                  win      <= pick_idx;
                  ptr      <= pick_idx;
                  mem_addr <= addr[pick_idx];
                  mem_din  <= wdata[pick_idx];
                  mem_we   <= we[pick_idx];
                  mem_rd   <= ~we[pick_idx];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT_ACC;
            end
            WAIT_ACC: begin
               if (!mem_ready)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (mem_ready) begin
                  if (mem_rd)
                     rdata <= mem_dout;
                  ack[win] <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_rd   <= 1'b0;
                  state    <= GAP;
               end
            end
            default: state <= GAP;
         endcase
      end
   end

   ack_onehot: assert property (@(posedge DDRAM_CLK) disable iff (reset) $onehot0(ack));
   strobe_excl: assert property (@(posedge DDRAM_CLK) disable iff (reset) !(mem_we && mem_rd));

endmodule
